// File: rtl/cmult_pkg.sv
// cmult_pkg: definitions shared by the complex-multiplier sequencer and its
// result buffer.
//   CMULT_OPW       operand width of the multiplier datapath
//   CMULT_PW        default product component width (2*CMULT_OPW + 1 growth bit)
//   cmult_state_e   tracking FSM states of the result buffer
//   cmult_res_t     real/imag result pair at the default width
package cmult_pkg;

    localparam int CMULT_OPW = 8;
    localparam int CMULT_PW  = 2 * CMULT_OPW + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        COMMIT = 2'd2
    } cmult_state_e;

    typedef struct packed {
        logic signed [CMULT_PW-1:0] re;
        logic signed [CMULT_PW-1:0] im;
    } cmult_res_t;

endpackage

// File: rtl/cmult_rb_fifo.sv
// cmult_rb_fifo: register-based synchronous FIFO with a show-ahead head.
//   clk, reset      clock and asynchronous active-high reset
//   push_i, data_i  write request and data; accepted when not full, or when
//                   full and a pop happens in the same cycle
//   pop_i           read request; ignored when empty
//   data_o          head entry; when empty it holds the last popped value
//   empty_o/full_o  occupancy flags
//   level_o         occupancy, 0..DEPTH
module cmult_rb_fifo #(
    parameter int W     = 34,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic [W-1:0]  data_i,
    input  logic          pop_i,
    output logic [W-1:0]  data_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [AW:0]   level_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  hold_q;
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // When full, the slot being popped this cycle is the one written next.
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            hold_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
                hold_q <= mem_q[rptr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

    // Empty: keep presenting the last value that left the FIFO.
    assign data_o  = empty_o ? hold_q : mem_q[rptr_q];
    assign level_o = cnt_q;

endmodule

// File: rtl/cmult_result_buffer.sv
// cmult_result_buffer: captures the real/imag product pair at the end of each
// complex multiplication, queues it and presents it on a valid/ready output.
// A reservation counter guarantees a FIFO slot for every started operation.
//   clk, reset         clock, asynchronous active-high reset
//   start_i            sequencer accepted a new multiplication (1-cycle pulse)
//   p_i_ce             sequencer imaginary-product load strobe (last step)
//   p_r, p_i           datapath product registers (signed)
//   accept             a result slot is available for a new start
//   out_valid/ready    downstream handshake; out_re/out_im show the head
//   level              FIFO occupancy
//   err_proto          sticky protocol error
//   err_timeout        sticky timeout error
// Optional macro CMULT_RB_CNT_EN adds res_cnt (completed pops) and drop_cnt
// (timeouts), both saturating.
module cmult_result_buffer
    import cmult_pkg::*;
#(
    parameter int PW      = CMULT_PW,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 8,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_i,
    input  logic          p_i_ce,
    input  logic [PW-1:0] p_r,
    input  logic [PW-1:0] p_i,
    output logic          accept,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_re,
    output logic [PW-1:0] out_im,
    output logic [AW:0]   level,
    output logic          err_proto,
    output logic          err_timeout
`ifdef CMULT_RB_CNT_EN
    ,
    output logic [15:0]   res_cnt,
    output logic [7:0]    drop_cnt
`endif
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    cmult_state_e  state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [AW:0]   rsv_q, rsv_d;
    logic          err_proto_q, err_proto_d;
    logic          err_timeout_q, err_timeout_d;

    logic          start_ok, push, pop, timeout, overflow;
    logic          fifo_empty, fifo_full;
    logic [2*PW-1:0] head;

    assign accept   = (rsv_q < (AW+1)'(DEPTH));
    assign start_ok = start_i && accept && (state_q != TRACK);
    assign pop      = out_valid && out_ready;
    // Should never happen while reservations are honoured.
    assign overflow = push && fifo_full && !pop;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        push    = 1'b0;
        timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = TRACK;
                    timer_d = '0;
                end
            end
            TRACK: begin
                if (p_i_ce) begin
                    state_d = COMMIT;
                end else if (timer_q == TMAX) begin
                    state_d = IDLE;
                    timeout = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            COMMIT: begin
                // Product registers were loaded by last cycle's p_i_ce.
                push = 1'b1;
                if (start_ok) begin
                    state_d = TRACK;
                    timer_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rsv_d         = rsv_q + (AW+1)'(start_ok) - (AW+1)'(pop) - (AW+1)'(timeout);
        err_timeout_d = err_timeout_q | timeout;
        err_proto_d   = err_proto_q
                      | (start_i && (!accept || state_q == TRACK))
                      | (p_i_ce && state_q != TRACK)
                      | overflow;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            rsv_q         <= '0;
            err_proto_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            rsv_q         <= rsv_d;
            err_proto_q   <= err_proto_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    cmult_rb_fifo #(
        .W     (2 * PW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .data_i  ({p_r, p_i}),
        .pop_i   (pop),
        .data_o  (head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .level_o (level)
    );

    assign out_valid   = !fifo_empty;
    assign out_re      = head[2*PW-1:PW];
    assign out_im      = head[PW-1:0];
    assign err_proto   = err_proto_q;
    assign err_timeout = err_timeout_q;

`ifdef CMULT_RB_CNT_EN
    logic [15:0] res_cnt_q;
    logic [7:0]  drop_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (pop && res_cnt_q != 16'hFFFF) res_cnt_q <= res_cnt_q + 1'b1;
            if (timeout && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign res_cnt  = res_cnt_q;
    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_cmult_result_buffer.sv
module tb_cmult_result_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic        p_i_ce;
    logic [16:0] p_r, p_i;
    logic        out_ready;
    logic        accept, out_valid, err_proto, err_timeout;
    logic [16:0] out_re, out_im;
    logic [2:0]  level;
`ifdef CMULT_RB_CNT_EN
    logic [15:0] res_cnt;
    logic [7:0]  drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cmult_result_buffer dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start_i),
        .p_i_ce      (p_i_ce),
        .p_r         (p_r),
        .p_i         (p_i),
        .accept      (accept),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_re      (out_re),
        .out_im      (out_im),
        .level       (level),
        .err_proto   (err_proto),
        .err_timeout (err_timeout)
`ifdef CMULT_RB_CNT_EN
        ,
        .res_cnt     (res_cnt),
        .drop_cnt    (drop_cnt)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        tick;
    endtask

    // Caller raises start_i in cycle 0; returns in cycle 5 (COMMIT) with
    // start_i = chain so the next operation can start back-to-back.
    task automatic do_op(input logic [16:0] re, input logic [16:0] im, input logic chain);
        tick;
        start_i = 1'b0;
        repeat (3) tick;
        p_i_ce = 1'b1;
        p_r = re;
        p_i = im;
        tick;
        p_i_ce = 1'b0;
        start_i = chain;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        checks++; if (accept !== 1'b1) begin errors++; $display("FAIL reset_accept got %b exp 1", accept); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
        checks++; if (out_re !== 17'h0 || out_im !== 17'h0) begin errors++; $display("FAIL reset_data got %h/%h exp 0/0", out_re, out_im); end
        checks++; if (err_proto !== 1'b0 || err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err got %b%b exp 00", err_proto, err_timeout); end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_single;
        start_i = 1'b1;
        do_op(17'h00123, 17'h1FF00, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b exp 0", out_valid); end
        tick;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", out_valid); end
        checks++; if (out_re !== 17'h00123) begin errors++; $display("FAIL single_re got %h exp 00123", out_re); end
        checks++; if (out_im !== 17'h1FF00) begin errors++; $display("FAIL single_im got %h exp 1ff00", out_im); end
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL single_level got %0d exp 1", level); end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        checks++; if (level !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got lvl %0d vld %b exp 0 0", level, out_valid); end
        checks++; if (out_re !== 17'h00123) begin errors++; $display("FAIL single_hold got %h exp 00123", out_re); end
        checks++; if (err_proto !== 1'b0) begin errors++; $display("FAIL single_proto got %b exp 0", err_proto); end
    endtask

    task automatic test_timeout;
        start_i = 1'b1;
        tick;
        start_i = 1'b0;
        repeat (7) tick;
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL timeout_early got %b exp 0", err_timeout); end
        tick;
        checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL timeout_flag got %b exp 1", err_timeout); end
        checks++; if (level !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL timeout_level got %0d vld %b exp 0 0", level, out_valid); end
        checks++; if (accept !== 1'b1) begin errors++; $display("FAIL timeout_accept got %b exp 1", accept); end
    endtask

    // Runs right after the timeout test: a leaked reservation would drop
    // accept one operation early.
    task automatic test_backpressure;
        out_ready = 1'b0;
        start_i = 1'b1;
        do_op(17'd1, 17'd11, 1'b1);
        do_op(17'd2, 17'd12, 1'b1);
        do_op(17'd3, 17'd13, 1'b1);
        checks++; if (accept !== 1'b1) begin errors++; $display("FAIL bp_accept3 got %b exp 1", accept); end
        do_op(17'd4, 17'd14, 1'b0);
        checks++; if (accept !== 1'b0) begin errors++; $display("FAIL bp_accept4 got %b exp 0", accept); end
        tick;
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL bp_level got %0d exp 4", level); end
        checks++; if (out_re !== 17'd1 || out_im !== 17'd11) begin errors++; $display("FAIL bp_head got %h/%h exp 1/b", out_re, out_im); end
        checks++; if (err_proto !== 1'b0) begin errors++; $display("FAIL bp_proto_pre got %b exp 0", err_proto); end
        start_i = 1'b1;
        tick;
        start_i = 1'b0;
        checks++; if (err_proto !== 1'b1) begin errors++; $display("FAIL bp_proto got %b exp 1", err_proto); end
        repeat (6) tick;
        checks++; if (level !== 3'd4 || accept !== 1'b0) begin errors++; $display("FAIL bp_untracked got lvl %0d acc %b exp 4 0", level, accept); end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        checks++; if (accept !== 1'b1 || level !== 3'd3) begin errors++; $display("FAIL bp_pop got acc %b lvl %0d exp 1 3", accept, level); end
        checks++; if (out_re !== 17'd2 || out_im !== 17'd12) begin errors++; $display("FAIL bp_next got %h/%h exp 2/c", out_re, out_im); end
    endtask

    task automatic test_push_pop;
        do_reset;
        out_ready = 1'b0;
        start_i = 1'b1;
        do_op(17'd1, 17'd21, 1'b0);
        tick;
        start_i = 1'b1;
        do_op(17'd2, 17'd22, 1'b0);
        tick;
        start_i = 1'b1;
        do_op(17'd3, 17'd23, 1'b0);
        checks++; if (level !== 3'd2 || out_re !== 17'd1) begin errors++; $display("FAIL pp_pre got lvl %0d re %h exp 2 1", level, out_re); end
        out_ready = 1'b1;
        tick;
        checks++; if (level !== 3'd2 || out_re !== 17'd2) begin errors++; $display("FAIL pp_same got lvl %0d re %h exp 2 2", level, out_re); end
        tick;
        checks++; if (level !== 3'd1 || out_re !== 17'd3 || out_im !== 17'd23) begin errors++; $display("FAIL pp_third got lvl %0d %h/%h exp 1 3/17", level, out_re, out_im); end
        tick;
        out_ready = 1'b0;
        checks++; if (level !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL pp_empty got lvl %0d vld %b exp 0 0", level, out_valid); end
    endtask

    task automatic test_stray_and_reset;
        do_reset;
        p_i_ce = 1'b1;
        tick;
        p_i_ce = 1'b0;
        checks++; if (err_proto !== 1'b1 || level !== 3'd0) begin errors++; $display("FAIL stray got proto %b lvl %0d exp 1 0", err_proto, level); end
        for (int k = 0; k < 3; k++) begin
            start_i = 1'b1;
            do_op(17'(k + 5), 17'(k + 9), 1'b0);
            tick;
        end
        start_i = 1'b1;
        tick;
        start_i = 1'b0;
        tick;
        checks++; if (level !== 3'd3 || out_re !== 17'd5) begin errors++; $display("FAIL mid_pre got lvl %0d re %h exp 3 5", level, out_re); end
        reset = 1'b1;
        #2;
        checks++; if (level !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_q got lvl %0d vld %b exp 0 0", level, out_valid); end
        checks++; if (out_re !== 17'h0 || out_im !== 17'h0) begin errors++; $display("FAIL mid_reset_data got %h/%h exp 0/0", out_re, out_im); end
        checks++; if (accept !== 1'b1 || err_proto !== 1'b0 || err_timeout !== 1'b0) begin errors++; $display("FAIL mid_reset_ctl got acc %b err %b%b exp 1 00", accept, err_proto, err_timeout); end
        tick;
        reset = 1'b0;
        repeat (10) tick;
        checks++; if (out_valid !== 1'b0 || err_timeout !== 1'b0) begin errors++; $display("FAIL post_reset got vld %b to %b exp 0 0", out_valid, err_timeout); end
    endtask

`ifdef CMULT_RB_CNT_EN
    task automatic test_counters;
        do_reset;
        checks++; if (res_cnt !== 16'd0 || drop_cnt !== 8'd0) begin errors++; $display("FAIL cnt_reset got %0d %0d exp 0 0", res_cnt, drop_cnt); end
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            start_i = 1'b1;
            do_op(17'(k), 17'(k), 1'b0);
            tick;
        end
        out_ready = 1'b1;
        repeat (4) tick;
        out_ready = 1'b0;
        start_i = 1'b1;
        tick;
        start_i = 1'b0;
        repeat (10) tick;
        checks++; if (res_cnt !== 16'd3) begin errors++; $display("FAIL res_cnt got %0d exp 3", res_cnt); end
        checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL drop_cnt got %0d exp 1", drop_cnt); end
    endtask
`endif

    initial begin
        reset = 1'b1;
        start_i = 1'b0;
        p_i_ce = 1'b0;
        p_r = '0;
        p_i = '0;
        out_ready = 1'b0;
        test_reset;
        test_single;
        test_timeout;
        test_backpressure;
        test_push_pop;
        test_stray_and_reset;
`ifdef CMULT_RB_CNT_EN
        test_counters;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmult_result_buffer.md
Name: cmult_result_buffer

Overview:
- Output-side companion to the complex-multiplier sequencer: captures the finished real/imag product pair after the sequencer's final load strobe (p_i_ce), queues it in a small FIFO and presents it downstream on a valid/ready handshake.
- Also returns backpressure (accept) to the input side so a multiplication is only started when a result slot is guaranteed.
- Sits between the complex-multiplier datapath product registers and the downstream consumer.

Parameters:
- PW, 17, width of each product component (2 x 8-bit operand product plus 1 growth bit).
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- TIMEOUT, 8, maximum cycles from start_i to p_i_ce before a tracked operation is abandoned.
- AW, $clog2(DEPTH), derived pointer width; not to be overridden.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start_i  in  1  single-cycle pulse: the sequencer accepted a new multiplication (step1 with input_rdy).
- p_i_ce  in  1  sequencer imaginary-product load strobe, i.e. the last step of an operation.
- p_r  in  PW  datapath real-product register, signed.
- p_i  in  PW  datapath imaginary-product register, signed.
- accept  out  1  slot available; upstream gates input_rdy with this.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream ready.
- out_re  out  PW  head real part.
- out_im  out  PW  head imaginary part.
- level  out  AW+1  FIFO occupancy, 0..DEPTH.
- err_proto  out  1  sticky protocol error.
- err_timeout  out  1  sticky timeout error.

Behaviour:
- Reset is asynchronous, active-high. At reset: FSM=IDLE, pointers/level/rsv_cnt/timer=0, out_valid=0, out_re/out_im=0, err_*=0, accept=1.
- Reservation counter rsv_cnt (0..DEPTH):
  - +1 on an accepted start.
  - -1 on a pop (out_valid && out_ready).
  - -1 on a timeout.
  - Simultaneous +1/-1 nets to zero.
  - accept = (rsv_cnt < DEPTH), decoded from registers only.
- Tracking FSM states are IDLE, TRACK and COMMIT.
  - IDLE: start_i && accept -> TRACK, timer=0.
  - TRACK: timer increments each cycle. p_i_ce -> COMMIT. Timer reaching TIMEOUT-1 without p_i_ce -> IDLE, set err_timeout, release the reservation.
  - COMMIT: lasts one cycle. Write {p_r,p_i} (now loaded by the datapath) into the FIFO. start_i && accept here -> TRACK, else -> IDLE.
- Latency:
  - p_i_ce high in cycle N; push at edge N+1; out_valid=1 from cycle N+2.
  - Nominal sequencer: start_i to out_valid = 6 cycles.
- Protocol errors (set err_proto, no state change, no push):
  - start_i while accept=0.
  - start_i in TRACK.
  - p_i_ce in IDLE or COMMIT.
- FIFO behaviour:
  - Head is shown directly on out_re/out_im; it holds stable while out_valid && !out_ready.
  - When empty, out_re/out_im hold their last values.
  - Push and pop in the same cycle are both performed; level is unchanged.
  - Pointers wrap modulo DEPTH.
  - Reservation guarantees no push when full. If one occurs anyway, drop the data, set err_proto, and leave pointers unchanged.
- Error flags: sticky; cleared only by reset.
- Reset mid-operation: the in-flight operation and all queued results are discarded; no further output until a new start_i.

Optional Feature:
- Macro: CMULT_RB_CNT_EN.
- Defined:
  - Adds output res_cnt [15:0]: count of completed pops.
  - Saturates at 16'hFFFF; reset value 0.
  - Adds output drop_cnt [7:0]: count of timeouts, saturating.
- Undefined: neither port exists and no counter logic is present; all other behaviour is identical.

Decomposition:
- Package cmult_pkg:
  - state enum {IDLE, TRACK, COMMIT}.
  - default PW.
  - result struct {re, im}.
  - shared with the sequencer package constants.
- One natural sub-module: cmult_rb_fifo.
  - Generic synchronous FIFO with push/pop/level.
  - Register-based storage, show-ahead head.
- FSM, reservation counter and error logic stay in the top module.

Test Plan:
- Single op: start_i at cycle 0, p_i_ce at cycle 4 with p_r=17'h00123, p_i=17'h1FF00 -> out_valid at cycle 6, out_re=17'h00123, out_im=17'h1FF00; with out_ready=1, level returns 0.
- Backpressure fill (DEPTH=4, out_ready=0): four back-to-back ops -> accept=0 after the 4th start; a 5th start_i sets err_proto and is not tracked; a single pop -> accept=1 the next cycle.
- Timeout: start_i with no p_i_ce -> after 8 cycles FSM=IDLE, err_timeout=1, rsv_cnt back to 0, level=0.
- Simultaneous push/pop at level=2 -> level stays 2; order preserved (FIFO order of values 1,2,3 at the output).
- Stray p_i_ce in IDLE -> err_proto=1, level unchanged. Then assert reset mid-TRACK with level=3 -> all outputs at reset values and accept=1 immediately.
- With CMULT_RB_CNT_EN: 3 pops plus 1 timeout -> res_cnt=3, drop_cnt=1.
